// File: rtl/trace_cache_core.sv
// trace_cache_core
//   Tag/state core of a trace-driven L1 data-cache model. Each clock it may
//   accept one (cmd, read_address) pair. The core splits the address and
//   updates a 4-way set-associative directory that holds valid, dirty, tag
//   and true-LRU age per way. It also maintains the read/write/hit/miss
//   statistics. No data is stored.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   cmd_valid, cmd        command strobe and 4-bit code
//                         (0 read, 1 write, 3 invalidate, 8 clear, 9 print)
//   read_address          trace address
//   tag/index/byte_select combinational split of read_address
//   rsp_valid             one-cycle pulse after each accepted command
//   rsp_hit               previous read/write hit
//   rsp_writeback         previous fill evicted a dirty line
//   victim_address        line address of that evicted dirty line
//   cache_read/write/hit/miss  wrapping statistics counters
module trace_cache_core #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 4,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 32,
  localparam int TAG_BITS   = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [3:0]             cmd,
  input  logic [ADDR_W-1:0]      read_address,
  output logic [TAG_BITS-1:0]    tag,
  output logic [INDEX_BITS-1:0]  index,
  output logic [OFFSET_BITS-1:0] byte_select,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_writeback,
  output logic [ADDR_W-1:0]      victim_address,
  output logic [CNT_W-1:0]       cache_read,
  output logic [CNT_W-1:0]       cache_write,
  output logic [CNT_W-1:0]       cache_hit,
  output logic [CNT_W-1:0]       cache_miss
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [3:0] {
    CMD_READ  = 4'd0,
    CMD_WRITE = 4'd1,
    CMD_INVAL = 4'd3,
    CMD_CLEAR = 4'd8,
    CMD_PRINT = 4'd9
  } cmd_e;

  logic                valid_q [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]    age_q   [SETS][WAYS];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             have_invalid;
  logic [WAY_W-1:0] invalid_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] access_way;
  logic [WAY_W-1:0] old_age;

  assign tag         = read_address[ADDR_W-1 -: TAG_BITS];
  assign index       = read_address[OFFSET_BITS +: INDEX_BITS];
  assign byte_select = read_address[OFFSET_BITS-1:0];

  // Directory lookup for the addressed set. The invalid-way scan runs from
  // the top down so the lowest-numbered invalid way wins. Ages are unique in
  // a set, so exactly one way carries the oldest age.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    have_invalid = 1'b0;
    invalid_way  = '0;
    lru_way      = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[index][w] && (tag_q[index][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[index][w]) begin
        have_invalid = 1'b1;
        invalid_way  = WAY_W'(w);
      end
      if (age_q[index][w] == WAY_W'(WAYS - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
    victim_way = have_invalid ? invalid_way : lru_way;
    access_way = hit ? hit_way : victim_way;
    old_age    = age_q[index][access_way];
  end

  // State update. Clear (cmd 8) rebuilds the same directory and counter
  // state as reset but leaves the last victim_address in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
      cache_read     <= '0;
      cache_write    <= '0;
      cache_hit      <= '0;
      cache_miss     <= '0;
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_writeback  <= 1'b0;
      victim_address <= '0;
    end else begin
      rsp_valid     <= cmd_valid;
      rsp_hit       <= 1'b0;
      rsp_writeback <= 1'b0;
      if (cmd_valid) begin
        case (cmd)
          CMD_READ, CMD_WRITE: begin
            if (cmd == CMD_READ) cache_read  <= cache_read + CNT_W'(1);
            else                 cache_write <= cache_write + CNT_W'(1);
            rsp_hit <= hit;
            for (int w = 0; w < WAYS; w++) begin
              if (age_q[index][w] < old_age) age_q[index][w] <= age_q[index][w] + WAY_W'(1);
            end
            age_q[index][access_way] <= '0;
            if (hit) begin
              cache_hit <= cache_hit + CNT_W'(1);
            end else begin
              cache_miss <= cache_miss + CNT_W'(1);
              if (valid_q[index][victim_way] && dirty_q[index][victim_way]) begin
                rsp_writeback  <= 1'b1;
                victim_address <= {tag_q[index][victim_way], index, {OFFSET_BITS{1'b0}}};
              end
              valid_q[index][access_way] <= 1'b1;
              tag_q[index][access_way]   <= tag;
              dirty_q[index][access_way] <= 1'b0;
            end
            if (cmd == CMD_WRITE) dirty_q[index][access_way] <= 1'b1;
          end
          CMD_INVAL: begin
            if (hit) begin
              valid_q[index][hit_way] <= 1'b0;
              dirty_q[index][hit_way] <= 1'b0;
            end
          end
          CMD_CLEAR: begin
            for (int s = 0; s < SETS; s++) begin
              for (int w = 0; w < WAYS; w++) begin
                valid_q[s][w] <= 1'b0;
                dirty_q[s][w] <= 1'b0;
                tag_q[s][w]   <= '0;
                age_q[s][w]   <= WAY_W'(w);
              end
            end
            cache_read  <= '0;
            cache_write <= '0;
            cache_hit   <= '0;
            cache_miss  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_cache_core.sv
// tb_trace_cache_core
//   Self-checking bench for trace_cache_core. It runs directed scenarios and
//   then randomized traffic. Expected values come from a reference model
//   that keeps each set as a recency-ordered list of ways (MRU first).
module tb_trace_cache_core;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [3:0]  cmd;
  logic [31:0] read_address;
  logic [21:0] tag;
  logic [3:0]  index;
  logic [5:0]  byte_select;
  logic        rsp_valid;
  logic        rsp_hit;
  logic        rsp_writeback;
  logic [31:0] victim_address;
  logic [31:0] cache_read;
  logic [31:0] cache_write;
  logic [31:0] cache_hit;
  logic [31:0] cache_miss;

  int num_checks = 0;
  int num_errors = 0;

  trace_cache_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd            (cmd),
    .read_address   (read_address),
    .tag            (tag),
    .index          (index),
    .byte_select    (byte_select),
    .rsp_valid      (rsp_valid),
    .rsp_hit        (rsp_hit),
    .rsp_writeback  (rsp_writeback),
    .victim_address (victim_address),
    .cache_read     (cache_read),
    .cache_write    (cache_write),
    .cache_hit      (cache_hit),
    .cache_miss     (cache_miss)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per-set valid/dirty/tag plus a recency list.
  bit          m_valid [16][4];
  bit          m_dirty [16][4];
  logic [31:0] m_tag   [16][4];
  int          order   [16][4];
  logic [31:0] m_read, m_write, m_hit, m_miss;
  bit          exp_hit, exp_wb;
  logic [31:0] exp_victim;

  function automatic void modelClear();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = 0;
        order[s][w]   = w;
      end
    end
    m_read = 0; m_write = 0; m_hit = 0; m_miss = 0;
  endfunction

  function automatic void modelTouch(int s, int way);
    int p = 0;
    for (int i = 0; i < 4; i++) if (order[s][i] == way) p = i;
    for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = way;
  endfunction

  function automatic void modelStep(logic [3:0] c, logic [31:0] a);
    int s, hw, way;
    logic [31:0] t;
    s  = int'((a >> 6) & 32'hF);
    t  = a >> 10;
    hw = -1;
    exp_hit = 0;
    exp_wb  = 0;
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (c == 4'd0 || c == 4'd1) begin
      if (c == 4'd0) m_read = m_read + 1; else m_write = m_write + 1;
      if (hw >= 0) begin
        exp_hit = 1;
        m_hit   = m_hit + 1;
        way     = hw;
      end else begin
        m_miss = m_miss + 1;
        way = -1;
        for (int w = 0; w < 4; w++) if (!m_valid[s][w] && way < 0) way = w;
        if (way < 0) way = order[s][3];
        if (m_valid[s][way] && m_dirty[s][way]) begin
          exp_wb     = 1;
          exp_victim = (m_tag[s][way] << 10) | (32'(s) << 6);
        end
        m_valid[s][way] = 1;
        m_tag[s][way]   = t;
        m_dirty[s][way] = 0;
      end
      if (c == 4'd1) m_dirty[s][way] = 1;
      modelTouch(s, way);
    end else if (c == 4'd3) begin
      if (hw >= 0) begin
        m_valid[s][hw] = 0;
        m_dirty[s][hw] = 0;
      end
    end else if (c == 4'd8) begin
      modelClear();
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic checkCounters();
    checkOutput("cache_read", cache_read, m_read);
    checkOutput("cache_write", cache_write, m_write);
    checkOutput("cache_hit", cache_hit, m_hit);
    checkOutput("cache_miss", cache_miss, m_miss);
  endtask

  task automatic checkResetState();
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_hit", 32'(rsp_hit), 32'd0);
    checkOutput("reset rsp_writeback", 32'(rsp_writeback), 32'd0);
    checkOutput("reset victim_address", victim_address, 32'd0);
    checkOutput("reset cache_read", cache_read, 32'd0);
    checkOutput("reset cache_write", cache_write, 32'd0);
    checkOutput("reset cache_hit", cache_hit, 32'd0);
    checkOutput("reset cache_miss", cache_miss, 32'd0);
  endtask

  // One accepted command: drive on the falling edge, check #1 after the
  // rising edge against the model.
  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a);
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd          = c;
    read_address = a;
    modelStep(c, a);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
    checkOutput("rsp_writeback", 32'(rsp_writeback), 32'(exp_wb));
    if (exp_wb) checkOutput("victim_address", victim_address, exp_victim);
    checkCounters();
  endtask

  task automatic idleCycle(input logic [3:0] c, input logic [31:0] a);
    @(negedge clk);
    cmd_valid    = 1'b0;
    cmd          = c;
    read_address = a;
    @(posedge clk);
    #1;
    checkOutput("idle rsp_valid", 32'(rsp_valid), 32'd0);
    checkCounters();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int r;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd          = 4'd0;
    read_address = 32'h0000_1044;
    modelClear();
    exp_victim   = 32'd0;
    #1;
    // Address split needs no clock.
    checkOutput("split tag", 32'(tag), 32'h4);
    checkOutput("split index", 32'(index), 32'h1);
    checkOutput("split byte_select", 32'(byte_select), 32'h4);
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;

    // Read miss then hit in the same line.
    applyStimulus(4'd0, 32'h0000_1040);
    applyStimulus(4'd0, 32'h0000_1048);
    checkOutput("t2 read", cache_read, 32'd2);
    checkOutput("t2 hit", cache_hit, 32'd1);
    checkOutput("t2 miss", cache_miss, 32'd1);

    // Print leaves counters alone; clear zeroes them.
    applyStimulus(4'd9, 32'h0000_1040);
    checkOutput("print read", cache_read, 32'd2);
    applyStimulus(4'd8, 32'h0);
    checkOutput("clear read", cache_read, 32'd0);
    checkOutput("clear hit", cache_hit, 32'd0);
    applyStimulus(4'd0, 32'h0000_1040);
    checkOutput("after clear hit", 32'(rsp_hit), 32'd0);
    applyStimulus(4'd8, 32'h0);

    // LRU eviction of a dirty line.
    applyStimulus(4'd1, 32'h0000_1040);
    applyStimulus(4'd0, 32'h0000_1440);
    applyStimulus(4'd0, 32'h0000_1840);
    applyStimulus(4'd0, 32'h0000_1C40);
    applyStimulus(4'd0, 32'h0000_2040);
    checkOutput("evict writeback", 32'(rsp_writeback), 32'd1);
    checkOutput("evict victim", victim_address, 32'h0000_1040);
    applyStimulus(4'd0, 32'h0000_1040);
    checkOutput("evicted line hit", 32'(rsp_hit), 32'd0);
    checkOutput("t3 read", cache_read, 32'd5);
    checkOutput("t3 write", cache_write, 32'd1);
    checkOutput("t3 hit", cache_hit, 32'd0);
    checkOutput("t3 miss", cache_miss, 32'd6);

    // Invalidate drops a dirty line without writeback.
    applyStimulus(4'd8, 32'h0);
    applyStimulus(4'd1, 32'h0000_1040);
    applyStimulus(4'd3, 32'h0000_1040);
    checkOutput("inval write", cache_write, 32'd1);
    checkOutput("inval miss", cache_miss, 32'd1);
    applyStimulus(4'd0, 32'h0000_1040);
    checkOutput("inval reread hit", 32'(rsp_hit), 32'd0);
    checkOutput("inval reread wb", 32'(rsp_writeback), 32'd0);

    // Randomized traffic on a small tag/index pool to force reuse.
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 7) << 10) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      r = $urandom_range(0, 99);
      if (r < 40)      applyStimulus(4'd0, a);
      else if (r < 75) applyStimulus(4'd1, a);
      else if (r < 85) applyStimulus(4'd3, a);
      else if (r < 90) applyStimulus(4'd9, a);
      else if (r < 94) applyStimulus(4'(10 + $urandom_range(0, 5)), a);
      else if (r < 95) applyStimulus(4'd8, a);
      else             idleCycle(4'(r & 1), a);
      if (i % 50 == 49) begin
        checkOutput("invariant", cache_hit + cache_miss, cache_read + cache_write);
      end
    end

    // Asynchronous reset asserted between edges during a write.
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd          = 4'd1;
    read_address = 32'h0000_1040;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState();
    @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    modelClear();
    applyStimulus(4'd0, 32'h0000_1040);
    checkOutput("post reset hit", 32'(rsp_hit), 32'd0);
    checkOutput("post reset read", cache_read, 32'd1);
    checkOutput("post reset write", cache_write, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
